counter_cmd_sched: RTL and testbench
====================================

Name: counter_cmd_sched

Overview:
- Shares one up_down_counter_3to12 instance (mod 3..12 wrap counter: sync load, up/down, always counts when load=0) between NREQ requesters.
- Accepts LOAD / UP-N / DOWN-N / READ commands through valid/ready handshakes and arbitrates round-robin.
- Sequences the counter's load, up_down and d pins cycle by cycle and returns the resulting counter value to the winning requester.
- Holds the counter value when idle by self-loading.

Parameters:
- NREQ, 2, number of requesters (2..8).
- STEP_W, 4, width of step-count argument.
- IDW, 3, width of requester id fields (at least clog2(NREQ)).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- req_valid  input  NREQ  per-requester command valid.
- req_op  input  2*NREQ  per-requester op: 00 READ, 01 LOAD, 10 UP, 11 DOWN.
- req_arg  input  STEP_W*NREQ  per-requester argument: load value (low 4 bits) or step count N.
- req_ready  output  NREQ  one-hot accept pulse.
- cnt_q  input  4  counter output q.
- cnt_load  output  1  drives counter load.
- cnt_up_down  output  1  drives counter up_down.
- cnt_d  output  4  drives counter d.
- done_valid  output  1  one-cycle completion pulse.
- done_id  output  IDW  requester id of the completed command.
- done_value  output  4  counter value after the command.
- done_err  output  1  set with done_valid when a LOAD was rejected.
- busy  output  1  high in every state except IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE → EXEC on accept.
  - EXEC → STEP when the op is UP/DOWN with N>0.
  - EXEC → DONE for LOAD, READ, or N=0.
  - STEP → DONE when the remaining count reaches 0.
  - DONE → IDLE unconditionally.
- Counter pin drive:
  - cnt_load=1 and cnt_d=cnt_q (hold) in IDLE, DONE, and EXEC of READ/UP/DOWN.
  - EXEC of a valid LOAD: cnt_load=1, cnt_d=arg[3:0].
  - STEP: cnt_load=0; cnt_up_down=1 for UP, 0 for DOWN.
  - Outside STEP, cnt_up_down=1.
  - All counter pins are combinational from state, latched command and cnt_q.
- Arbitration:
  - Arbitrate only in IDLE, among asserted req_valid.
  - Round-robin: search starts at last_grant+1 mod NREQ. After reset, last_grant=NREQ-1, so req0 has first priority.
  - req_ready is high for the winner in the accept cycle only.
  - On accept, latch op, arg and id; update last_grant.
  - Requesters hold valid/op/arg stable until ready; ready is never asserted outside IDLE.
- STEP uses a down-counter of width STEP_W loaded with N; exactly N counter steps occur. Wrap 12→3 and 3→12 is left to the counter.
- LOAD range check: an arg[3:0] outside 3..12 is rejected. In that case:
  - EXEC holds instead of loading;
  - DONE reports done_err=1 and done_value = unchanged cnt_q.
- DONE cycle: done_valid=1, done_id=latched id, done_value=cnt_q (already reflects the final update), done_err per the range check.
- Latency from accept edge to done_valid:
  - LOAD, READ or N=0: 2 cycles.
  - UP/DOWN with N>0: N+2 cycles.
- Reset values: state IDLE; req_ready=0; done_valid=0; done_err=0; done_id=0; done_value=0; busy=0; step count 0; last_grant=NREQ-1.
- Reset mid-operation: the command is abandoned with no done pulse. The counter is reset to 3 by its own reset, which is tied to the same reset.
- During reset, cnt_load=1 and cnt_d=cnt_q (harmless, since the counter's reset has priority).

Decomposition:
- Package counter_sched_pkg holds:
  - typedef op_e (OP_READ, OP_LOAD, OP_UP, OP_DOWN);
  - typedef state_e (IDLE, EXEC, STEP, DONE);
  - constants CNT_MIN=3, CNT_MAX=12.
- One sub-module: rr_arbiter (NREQ-wide round-robin, inputs req and advance, outputs one-hot gnt and index).
- A top-level wrapper instantiating counter_cmd_sched plus up_down_counter_3to12 is used by the bench.

Test Plan:
- Reset, then 5 idle cycles → q stays 3, busy=0, no done_valid.
- Req0 LOAD 7, then req0 UP N=7 → first done_value=7, latency 2; second: q steps 8,9,10,11,12,3,4, done_value=4, latency 9.
- Req1 DOWN N=2 from q=4 → q 3 then 12, done_value=12, done_id=1.
- Req0 and req1 both valid with LOAD 5 / LOAD 9, repeated twice → grants alternate 0,1,0,1; final done_value=9.
- Req0 LOAD 14 at q=9 → done_err=1, done_value=9, q unchanged; UP N=0 → done_value=9, latency 2.
- Reset asserted in STEP of UP N=6 → no done pulse, q=3 the next cycle, busy=0, and req0 wins the next arbitration.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter command scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT_MIN = 4'd3;
  localparam logic [3:0] CNT_MAX = 4'd12;

  function automatic logic load_in_range(input logic [3:0] v);
    return (v >= CNT_MIN) && (v <= CNT_MAX);
  endfunction

endpackage

// File: rtl/counter_cmd_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] last_grant;
  int             j;

  // Scan from the farthest candidate to the nearest so the nearest asserted one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      j = (int'(last_grant) + i) % NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (advance) begin
      last_grant <= idx;
    end
  end

endmodule

// File: rtl/counter_cmd_sched.sv
// Schedules LOAD/UP/DOWN/READ commands from NREQ requesters onto one shared
// mod 3..12 counter and reports the resulting value to the winner.
module counter_cmd_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int STEP_W = 4,
  parameter int IDW    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [STEP_W*NREQ-1:0] req_arg,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3:0]             cnt_q,
  output logic                   cnt_load,
  output logic                   cnt_up_down,
  output logic [3:0]             cnt_d,
  output logic                   done_valid,
  output logic [IDW-1:0]         done_id,
  output logic [3:0]             done_value,
  output logic                   done_err,
  output logic                   busy
);

  state_e              state;
  op_e                 op_r;
  logic [STEP_W-1:0]   arg_r;
  logic [IDW-1:0]      id_r;
  logic                err_r;
  logic [STEP_W-1:0]   step_cnt;

  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                advance;
  op_e                 sel_op;
  logic [STEP_W-1:0]   sel_arg;

  assign advance = (state == IDLE) && (|req_valid);
  assign sel_op  = op_e'(req_op[int'(gnt_idx)*2 +: 2]);
  assign sel_arg = req_arg[int'(gnt_idx)*STEP_W +: STEP_W];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign req_ready = advance ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (advance) begin
            state <= EXEC;
            err_r <= (sel_op == OP_LOAD) && !load_in_range(sel_arg[3:0]);
          end
        end
        EXEC: begin
          if (((op_r == OP_UP) || (op_r == OP_DOWN)) && (arg_r != '0)) begin
            state    <= STEP;
            step_cnt <= arg_r;
          end else begin
            state <= DONE;
          end
        end
        // One counter step per cycle; leave after the N-th.
        STEP: begin
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == STEP_W'(1)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      op_r  <= sel_op;
      arg_r <= sel_arg;
      id_r  <= gnt_idx;
    end
  end

  // The counter always steps when load is low, so holding means reloading q.
  always_comb begin
    cnt_load    = 1'b1;
    cnt_up_down = 1'b1;
    cnt_d       = cnt_q;
    if (state == STEP) begin
      cnt_load    = 1'b0;
      cnt_up_down = (op_r == OP_UP);
    end else if ((state == EXEC) && (op_r == OP_LOAD) && !err_r) begin
      cnt_d = arg_r[3:0];
    end
  end

  assign done_valid = (state == DONE);
  assign done_id    = (state == DONE) ? id_r : '0;
  assign done_value = (state == DONE) ? cnt_q : '0;
  assign done_err   = (state == DONE) && err_r;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Bench for counter_cmd_sched: emulates the shared counter, applies a vector
// table, hand sequences and random commands against an arithmetic model.
module tb_counter_cmd_sched;

  localparam int NREQ   = 2;
  localparam int STEP_W = 4;
  localparam int IDW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [2*NREQ-1:0]      req_op;
  logic [STEP_W*NREQ-1:0] req_arg;
  logic [NREQ-1:0]        req_ready;
  logic [3:0]             cnt_q;
  logic                   cnt_load;
  logic                   cnt_up_down;
  logic [3:0]             cnt_d;
  logic                   done_valid;
  logic [IDW-1:0]         done_id;
  logic [3:0]             done_value;
  logic                   done_err;
  logic                   busy;

  int n_vec = 0;
  int n_err = 0;
  int model_q = 3;

  counter_cmd_sched #(
    .NREQ   (NREQ),
    .STEP_W (STEP_W),
    .IDW    (IDW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_arg     (req_arg),
    .req_ready   (req_ready),
    .cnt_q       (cnt_q),
    .cnt_load    (cnt_load),
    .cnt_up_down (cnt_up_down),
    .cnt_d       (cnt_d),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_value  (done_value),
    .done_err    (done_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Shared mod 3..12 up/down counter the scheduler drives.
  always @(posedge clk) begin
    if (reset) cnt_q <= 4'd3;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_up_down) cnt_q <= (cnt_q == 4'd12) ? 4'd3 : cnt_q + 4'd1;
    else cnt_q <= (cnt_q == 4'd3) ? 4'd12 : cnt_q - 4'd1;
  end

  typedef struct {
    int rid;
    int op;
    int arg;
    int val;
    int err;
    int lat;
  } vec_t;

  vec_t tbl1[3];
  vec_t tbl2[2];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Expected result from the command semantics: value ring 3..12 of size 10.
  task automatic model(input int op, input int arg, output int v, output int e, output int l);
    int a4;
    a4 = arg % 16;
    e  = 0;
    l  = 2;
    v  = model_q;
    case (op)
      1: if (a4 >= 3 && a4 <= 12) v = a4; else e = 1;
      2: begin v = ((model_q - 3 + arg) % 10) + 3; l = (arg == 0) ? 2 : arg + 2; end
      3: begin v = (((model_q - 3 - arg) % 10) + 10) % 10 + 3; l = (arg == 0) ? 2 : arg + 2; end
      default: ;
    endcase
  endtask

  // Caller is just after a negedge with the DUT idle; returns at a negedge in IDLE.
  task automatic run_cmd(input int rid, input int op, input int arg,
                         input int ev, input int ee, input int el, input string tag);
    int w;
    int lat;
    req_valid = '0;
    req_valid[rid] = 1'b1;
    req_op[rid*2 +: 2] = 2'(op);
    req_arg[rid*STEP_W +: STEP_W] = STEP_W'(arg);
    #1;
    w = 0;
    while (!req_ready[rid] && w < 50) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "_ready"}, int'(req_ready[rid]), 1);
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    #1;
    while (!done_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, el);
    check({tag, "_id"}, int'(done_id), rid);
    check({tag, "_value"}, int'(done_value), ev);
    check({tag, "_err"}, int'(done_err), ee);
    @(negedge clk);
  endtask

  initial begin
    int ev, ee, el, w;
    tbl1[0] = '{rid: 0, op: 1, arg: 7,  val: 7,  err: 0, lat: 2};
    tbl1[1] = '{rid: 0, op: 2, arg: 7,  val: 4,  err: 0, lat: 9};
    tbl1[2] = '{rid: 1, op: 3, arg: 2,  val: 12, err: 0, lat: 4};
    tbl2[0] = '{rid: 0, op: 1, arg: 14, val: 9,  err: 1, lat: 2};
    tbl2[1] = '{rid: 0, op: 2, arg: 0,  val: 9,  err: 0, lat: 2};

    reset = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_arg = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_done_valid", int'(done_valid), 0);
    check("rst_done_value", int'(done_value), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_done_err", int'(done_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt_load", int'(cnt_load), 1);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_q", int'(cnt_q), 3);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done_valid), 0);
    end

    for (int i = 0; i < 3; i++)
      run_cmd(tbl1[i].rid, tbl1[i].op, tbl1[i].arg, tbl1[i].val, tbl1[i].err, tbl1[i].lat, "tbl1");
    check("after_down_q", int'(cnt_q), 12);

    // Two competing LOADs held valid: grants must alternate 0,1,0,1.
    req_op = {2'b01, 2'b01};
    req_arg = {4'd9, 4'd5};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = 0;
      while (req_ready == '0 && w < 50) begin
        @(negedge clk); #1; w++;
      end
      check("rr_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
      @(negedge clk);
      if (k == 3) req_valid = '0;
      #1;
      w = 0;
      while (!done_valid && w < 40) begin
        @(negedge clk); #1; w++;
      end
      check("rr_done_id", int'(done_id), k % 2);
      check("rr_done_value", int'(done_value), (k % 2 == 0) ? 5 : 9);
      @(negedge clk);
    end

    for (int i = 0; i < 2; i++)
      run_cmd(tbl2[i].rid, tbl2[i].op, tbl2[i].arg, tbl2[i].val, tbl2[i].err, tbl2[i].lat, "tbl2");
    check("bad_load_q", int'(cnt_q), 9);

    // Reset while stepping UP 6 from 9.
    req_valid = 2'b01;
    req_op = 4'b0010;
    req_arg = 8'h06;
    #1;
    w = 0;
    while (!req_ready[0] && w < 50) begin
      @(negedge clk); #1; w++;
    end
    check("midrst_ready", int'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("midrst_stepping", int'(cnt_load), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_q", int'(cnt_q), 3);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done_valid), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done_valid), 0);
    end
    req_op = '0;
    req_valid = 2'b11;
    #1;
    check("midrst_req0_first", int'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    #1;
    w = 0;
    while (!done_valid && w < 40) begin
      @(negedge clk); #1; w++;
    end
    check("midrst_read_id", int'(done_id), 0);
    check("midrst_read_value", int'(done_value), 3);
    @(negedge clk);
    model_q = 3;

    for (int i = 0; i < 40; i++) begin
      int rid, op, arg;
      rid = int'($urandom_range(0, NREQ - 1));
      op  = int'($urandom_range(0, 3));
      arg = int'($urandom_range(0, 15));
      model(op, arg, ev, ee, el);
      run_cmd(rid, op, arg, ev, ee, el, "rand");
      model_q = ev;
      check("rand_q_hold", int'(cnt_q), model_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
